digest_tx_port: RTL and testbench

//  Returns the finished SHA-256 digest (h0..h7) from the hash core to software.

---
 rtl/digest_tx_port.sv | 198 +++++++++++++++++++
 tb/tb_digest_tx_port.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/digest_tx_port.sv
// Purpose : serialise a captured 256-bit SHA-256 digest (h0..h7) to software over the to_sw/to_hw PIO handshake.
// Latency : capture visible 1 cycle after digest_valid; each handshake edge reflected 1 cycle later (3 with DIGEST_TX_SYNC_EN).
// Backpres: each word is held with code 01 until software acks; digest_valid is ignored while busy.
// Option  : define DIGEST_TX_SYNC_EN to pass to_hw_sig through a 2-flop synchroniser (PIO in another clock domain).
module digest_tx_port #(
  parameter  int WORD_W = 32,
  parameter  int NWORDS = 8,
  localparam int IDX_W  = $clog2(NWORDS),
  localparam int DIG_W  = WORD_W * NWORDS
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              digest_valid,
  input  logic [DIG_W-1:0]  digest_in,
  input  logic [1:0]        to_hw_sig,
  output logic [WORD_W-1:0] to_sw_port,
  output logic [1:0]        to_sw_sig,
  output logic [IDX_W-1:0]  word_idx,
  output logic              busy,
  output logic              tx_done
);

  // Software-to-hardware codes
  localparam logic [1:0] HW_RELEASE = 2'b00;
  localparam logic [1:0] HW_ACK     = 2'b01;
  localparam logic [1:0] HW_DONE    = 2'b11;
  localparam logic [1:0] HW_ABORT   = 2'b10;

  // Hardware-to-software codes
  localparam logic [1:0] SW_IDLE    = 2'b00;
  localparam logic [1:0] SW_VALID   = 2'b01;
  localparam logic [1:0] SW_ALL     = 2'b11;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESENT = 2'd1,
    S_RELEASE = 2'd2,
    S_FINISH  = 2'd3
  } state_t;

  state_t              r_state;
  logic [DIG_W-1:0]    r_digest;
  logic [WORD_W-1:0]   r_port;
  logic [1:0]          r_sig;
  logic [IDX_W-1:0]    r_idx;
  logic                r_busy;
  logic                r_done;

  state_t              w_state_nxt;
  logic [DIG_W-1:0]    w_digest_nxt;
  logic [WORD_W-1:0]   w_port_nxt;
  logic [1:0]          w_sig_nxt;
  logic [IDX_W-1:0]    w_idx_nxt;
  logic                w_busy_nxt;
  logic                w_done_nxt;

  logic [1:0]          w_hw;
  logic                w_abort;
  logic [IDX_W-1:0]    w_idx_inc;
  logic [WORD_W-1:0]   w_next_word;

  // Word i of the held digest; h0 sits in the most significant slot.
  function automatic logic [WORD_W-1:0] pick_word(input logic [DIG_W-1:0] dig,
                                                  input logic [IDX_W-1:0] idx);
    logic [DIG_W-1:0] shifted;
    shifted   = dig >> ((NWORDS - 1 - int'(idx)) * WORD_W);
    pick_word = shifted[WORD_W-1:0];
  endfunction

`ifdef DIGEST_TX_SYNC_EN
  logic [1:0] r_hw_meta;
  logic [1:0] r_hw_sync;

  // Two-flop synchroniser for the software code; resets to the release code.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_hw_meta <= HW_RELEASE;
      r_hw_sync <= HW_RELEASE;
    end else begin
      r_hw_meta <= to_hw_sig;
      r_hw_sync <= r_hw_meta;
    end
  end

  assign w_hw = r_hw_sync;
`else
  assign w_hw = to_hw_sig;
`endif

  assign w_abort     = (w_hw == HW_ABORT);
  assign w_idx_inc   = r_idx + 1'b1;
  assign w_next_word = pick_word(r_digest, w_idx_inc);

  // State and output registers; reset clears everything, including the held digest.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_state  <= S_IDLE;
      r_digest <= '0;
      r_port   <= '0;
      r_sig    <= SW_IDLE;
      r_idx    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_digest <= w_digest_nxt;
      r_port   <= w_port_nxt;
      r_sig    <= w_sig_nxt;
      r_idx    <= w_idx_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

  // Next-state and next-output logic; abort overrides every non-idle decision.
  always_comb begin
    w_state_nxt  = r_state;
    w_digest_nxt = r_digest;
    w_port_nxt   = r_port;
    w_sig_nxt    = r_sig;
    w_idx_nxt    = r_idx;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;

    case (r_state)
      S_IDLE: begin
        // Abort code is meaningless here and falls through untouched.
        if (digest_valid) begin
          w_digest_nxt = digest_in;
          w_idx_nxt    = '0;
          w_port_nxt   = digest_in[DIG_W-1 -: WORD_W];
          w_sig_nxt    = SW_VALID;
          w_busy_nxt   = 1'b1;
          w_state_nxt  = S_PRESENT;
        end
      end

      S_PRESENT: begin
        // Word stays on the port until software acknowledges it.
        if (w_hw == HW_ACK) begin
          w_sig_nxt   = SW_IDLE;
          w_state_nxt = S_RELEASE;
        end
      end

      S_RELEASE: begin
        // Software must drop its ack before the next word is offered.
        if (w_hw == HW_RELEASE) begin
          if (r_idx == LAST_IDX) begin
            w_sig_nxt   = SW_ALL;
            w_state_nxt = S_FINISH;
          end else begin
            w_idx_nxt   = w_idx_inc;
            w_port_nxt  = w_next_word;
            w_sig_nxt   = SW_VALID;
            w_state_nxt = S_PRESENT;
          end
        end
      end

      S_FINISH: begin
        // The last word stays on the port after completion.
        if (w_hw == HW_DONE) begin
          w_done_nxt  = 1'b1;
          w_sig_nxt   = SW_IDLE;
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_sig_nxt   = SW_IDLE;
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase

    // Abort wins over everything else, including a coincident digest_valid.
    if ((r_state != S_IDLE) && w_abort) begin
      w_done_nxt   = 1'b0;
      w_sig_nxt    = SW_IDLE;
      w_busy_nxt   = 1'b0;
      w_idx_nxt    = r_idx;
      w_port_nxt   = r_port;
      w_digest_nxt = r_digest;
      w_state_nxt  = S_IDLE;
    end
  end

  assign to_sw_port = r_port;
  assign to_sw_sig  = r_sig;
  assign word_idx   = r_idx;
  assign busy       = r_busy;
  assign tx_done    = r_done;

endmodule

// File: tb/tb_digest_tx_port.sv
// Bench for digest_tx_port: directed sequence with random digests and random software delays.
// Expected words come from slicing the 256-bit digest arithmetically; handshake lag is checked per edge.
// Works in both builds; the expected lag follows DIGEST_TX_SYNC_EN.
module tb_digest_tx_port;

`ifdef DIGEST_TX_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic         clk;
  logic         Reset;
  logic         digest_valid;
  logic [255:0] digest_in;
  logic [1:0]   to_hw_sig;
  logic [31:0]  to_sw_port;
  logic [1:0]   to_sw_sig;
  logic [2:0]   word_idx;
  logic         busy;
  logic         tx_done;

  int checks = 0;
  int errors = 0;

  digest_tx_port dut (
    .clk          (clk),
    .Reset        (Reset),
    .digest_valid (digest_valid),
    .digest_in    (digest_in),
    .to_hw_sig    (to_hw_sig),
    .to_sw_port   (to_sw_port),
    .to_sw_sig    (to_sw_sig),
    .word_idx     (word_idx),
    .busy         (busy),
    .tx_done      (tx_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: word i of a digest is the i-th 32-bit group counted from the top.
  function automatic logic [31:0] ref_word(input logic [255:0] d, input int i);
    logic [255:0] s;
    s = d >> (32 * (7 - i));
    return s[31:0];
  endfunction

  function automatic logic [255:0] rand_digest();
    logic [255:0] d;
    d = '0;
    for (int i = 0; i < 8; i++) d = {d[223:0], 32'($urandom)};
    return d;
  endfunction

  // Advance until to_sw_sig leaves 'old'; the number of edges must equal LAT.
  task automatic wait_change(input string tag, input logic [1:0] old, input logic [1:0] nw);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (to_sw_sig == old && n < 20);
    chk({tag, "_lag"}, 256'(n), 256'(LAT));
    chk({tag, "_sig"}, 256'(to_sw_sig), 256'(nw));
  endtask

  task automatic capture(input logic [255:0] d);
    digest_in    = d;
    digest_valid = 1'b1;
    tick();
    digest_valid = 1'b0;
    chk("cap_port", 256'(to_sw_port), 256'(ref_word(d, 0)));
    chk("cap_sig",  256'(to_sw_sig),  256'(2'b01));
    chk("cap_idx",  256'(word_idx),   256'(0));
    chk("cap_busy", 256'(busy),       256'(1));
  endtask

  task automatic settle();
    to_hw_sig = 2'b00;
    repeat (LAT + 1) tick();
  endtask

  // One full transfer; abort_at/overrun_at select the word for those events (-1 = none).
  task automatic xfer(input logic [255:0] d, input int abort_at, input int overrun_at);
    int hold;
    capture(d);
    for (int i = 0; i < 8; i++) begin
      chk("w_port", 256'(to_sw_port), 256'(ref_word(d, i)));
      chk("w_idx",  256'(word_idx),   256'(i));
      chk("w_sig",  256'(to_sw_sig),  256'(2'b01));
      chk("w_busy", 256'(busy),       256'(1));
      hold = int'($urandom_range(0, 3));
      repeat (hold) begin
        tick();
        chk("hold", 256'({to_sw_port, to_sw_sig, word_idx}), 256'({ref_word(d, i), 2'b01, 3'(i)}));
      end
      if (i == overrun_at) begin
        digest_in    = '1;
        digest_valid = 1'b1;
        tick();
        digest_valid = 1'b0;
        chk("ovr_port", 256'(to_sw_port), 256'(ref_word(d, i)));
        chk("ovr_idx",  256'(word_idx),   256'(i));
        chk("ovr_sig",  256'(to_sw_sig),  256'(2'b01));
      end
      if (i == abort_at) begin
        to_hw_sig = 2'b10;
        wait_change("abort", 2'b01, 2'b00);
        chk("abort_busy", 256'(busy), 256'(0));
        chk("abort_done", 256'(tx_done), 256'(0));
        to_hw_sig = 2'b00;
        repeat (LAT + 2) begin
          tick();
          chk("post_abort", 256'({busy, tx_done, to_sw_sig}), 256'(0));
        end
        return;
      end
      to_hw_sig = 2'b01;
      wait_change("ack", 2'b01, 2'b00);
      to_hw_sig = 2'b00;
      if (i < 7) wait_change("rel", 2'b00, 2'b01);
      else       wait_change("rel_last", 2'b00, 2'b11);
    end
    chk("fin_port", 256'(to_sw_port), 256'(ref_word(d, 7)));
    chk("fin_busy", 256'(busy), 256'(1));
    chk("fin_pre_done", 256'(tx_done), 256'(0));
    to_hw_sig = 2'b11;
    wait_change("done", 2'b11, 2'b00);
    chk("done_pulse", 256'(tx_done), 256'(1));
    chk("done_busy",  256'(busy),    256'(0));
    chk("done_port",  256'(to_sw_port), 256'(ref_word(d, 7)));
    to_hw_sig = 2'b00;
    tick();
    chk("done_end", 256'(tx_done), 256'(0));
    repeat (LAT) tick();
  endtask

  initial begin
    logic [255:0] d;
    clk          = 1'b0;
    Reset        = 1'b0;
    digest_valid = 1'b0;
    digest_in    = '0;
    to_hw_sig    = 2'b00;

    // Reset takes effect without a clock edge
    #1 Reset = 1'b1;
    #1;
    chk("rst_port", 256'(to_sw_port), 256'(0));
    chk("rst_sig",  256'(to_sw_sig),  256'(0));
    chk("rst_idx",  256'(word_idx),   256'(0));
    chk("rst_busy", 256'(busy),       256'(0));
    chk("rst_done", 256'(tx_done),    256'(0));
    tick();
    tick();
    Reset = 1'b0;
    tick();

    // Abort code in IDLE is ignored
    to_hw_sig = 2'b10;
    repeat (LAT + 2) begin
      tick();
      chk("idle_abort", 256'({busy, to_sw_sig, tx_done}), 256'(0));
    end
    settle();

    // Full transfer of the "abc" digest
    xfer(256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad, -1, -1);

    // Slow software, ignored 11 in PRESENT, then abort coinciding with digest_valid
    d = rand_digest();
    capture(d);
    repeat (50) begin
      tick();
      chk("slow", 256'({to_sw_port, to_sw_sig, word_idx, busy}), 256'({ref_word(d, 0), 2'b01, 3'd0, 1'b1}));
    end
    to_hw_sig = 2'b11;
    repeat (LAT + 3) begin
      tick();
      chk("ign_11", 256'(to_sw_sig), 256'(2'b01));
    end
    to_hw_sig = 2'b10;
    repeat (LAT - 1) tick();
    digest_in    = '1;
    digest_valid = 1'b1;
    tick();
    digest_valid = 1'b0;
    chk("abdv_sig",  256'(to_sw_sig), 256'(0));
    chk("abdv_busy", 256'(busy),      256'(0));
    to_hw_sig = 2'b00;
    repeat (LAT + 2) begin
      tick();
      chk("abdv_idle", 256'({busy, to_sw_sig, tx_done}), 256'(0));
    end

    // Abort during word 3, then a restart from word 0
    xfer(rand_digest(), 3, -1);
    xfer(rand_digest(), -1, -1);

    // Busy overrun during word 2
    xfer(rand_digest(), -1, 2);

    // Reset mid-transfer
    d = rand_digest();
    capture(d);
    to_hw_sig = 2'b01;
    repeat (LAT) tick();
    to_hw_sig = 2'b00;
    #3 Reset = 1'b1;
    #1;
    chk("mrst", 256'({to_sw_port, to_sw_sig, word_idx, busy, tx_done}), 256'(0));
    #3 Reset = 1'b0;
    repeat (LAT + 1) begin
      tick();
      chk("mrst_idle", 256'({to_sw_sig, busy}), 256'(0));
    end

    // Further random transfers
    for (int k = 0; k < 3; k++) xfer(rand_digest(), -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
